// File: rtl/gc_poll_tx_if.sv
// gc_poll_tx_if: APB3 bus bundle between a bus master and gc_poll_tx.
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA (master to slave);
//          PRDATA, PREADY, PSLVERR (slave to master).
interface gc_poll_tx_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/gc_poll_tx.sv
// gc_poll_tx: periodic GameCube poll command transmitter with APB3 control/status.
// Ports: PCLK clock; PRESET sync active-high reset; apb APB3 slave (CTRL 0x0, STATUS 0x4);
//        data open-drain controller line (0 or Z); ready high during the response window;
//        poll_irq one-cycle end-of-window pulse (only when GC_POLL_IRQ_EN is defined).
// Optional feature macro: GC_POLL_IRQ_EN (poll_irq port, sticky STATUS bit2, clear via CTRL bit31).
module gc_poll_tx #(
    parameter int CLK_PER_US     = 100,
    parameter int POLL_PERIOD_US = 16000,
    parameter int RESP_WINDOW_US = 300
) (
    input  logic        PCLK,
    input  logic        PRESET,
    gc_poll_tx_if.slave apb,
    inout  wire         data,
    output logic        ready
`ifdef GC_POLL_IRQ_EN
    ,
    output logic        poll_irq
`endif
);
    localparam int Q       = CLK_PER_US;
    localparam int BIT_T   = 4 * Q;
    localparam int WIN_T   = RESP_WINDOW_US * Q;
    localparam int PER_T   = POLL_PERIOD_US * Q;
    localparam int CNT_MAX = WIN_T > BIT_T ? WIN_T : BIT_T;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int PW      = $clog2(PER_T);

    typedef enum logic [2:0] {IDLE, WAIT, LOAD, BIT_LOW, BIT_HIGH, STOP_LOW, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] per_cnt;
    logic [4:0]    bit_idx;
    logic [23:0]   cmd;
    logic          drive_low;
    logic [15:0]   frame_cnt;
    logic          en;
    logic          rumble;
    logic          irq;
    logic [CW-1:0] lo_last;
    logic          frame_done;
    logic          busy;
    logic          ctrl_wr;
    logic [31:0]   status;
    logic          unused;

    assign data       = drive_low ? 1'b0 : 1'bz;
    assign lo_last    = cmd[bit_idx] ? CW'(Q - 1) : CW'(3 * Q - 1);
    assign frame_done = state == RESP && cnt == CW'(WIN_T - 1);
    assign busy       = state != IDLE && state != WAIT;
    assign ctrl_wr    = apb.PSEL & apb.PENABLE & apb.PWRITE & (apb.PADDR[3:2] == 2'd0);
    assign status     = {frame_cnt, 13'b0, irq, ready, busy};
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign unused     = &{1'b0, apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA[31:2]};

    // drive_low and ready are registered alongside the state, so the line
    // follows the state one cycle later and ready can never coincide with a low.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            per_cnt   <= '0;
            bit_idx   <= '0;
            cmd       <= '0;
            drive_low <= 1'b0;
            ready     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
            cnt     <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    per_cnt <= '0;
                    if (en) state <= LOAD;
                end
                WAIT: begin
                    if (per_cnt == PW'(PER_T - 1)) begin
                        per_cnt <= '0;
                        state   <= en ? LOAD : IDLE;
                    end
                end
                LOAD: begin
                    cmd       <= {16'h4003, 7'b0, rumble};
                    bit_idx   <= 5'd23;
                    cnt       <= '0;
                    drive_low <= 1'b1;
                    state     <= BIT_LOW;
                end
                BIT_LOW: begin
                    if (cnt == lo_last) begin
                        drive_low <= 1'b0;
                        state     <= BIT_HIGH;
                    end
                end
                BIT_HIGH: begin
                    // cnt runs across the whole bit, so the high phase fills it to 4 us
                    if (cnt == CW'(BIT_T - 1)) begin
                        cnt       <= '0;
                        drive_low <= 1'b1;
                        if (bit_idx == 5'd0) begin
                            state <= STOP_LOW;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                            state   <= BIT_LOW;
                        end
                    end
                end
                STOP_LOW: begin
                    if (cnt == CW'(Q - 1)) begin
                        cnt       <= '0;
                        drive_low <= 1'b0;
                        ready     <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (frame_done) begin
                        ready     <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        state     <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en         <= 1'b0;
            rumble     <= 1'b0;
            apb.PRDATA <= '0;
        end else begin
            if (ctrl_wr) begin
                en     <= apb.PWDATA[0];
                rumble <= apb.PWDATA[1];
            end
            apb.PRDATA <= apb.PADDR[3:2] == 2'd0 ? {30'b0, rumble, en} :
                          apb.PADDR[3:2] == 2'd1 ? status : '0;
        end
    end

`ifdef GC_POLL_IRQ_EN
    // set has priority over a same-cycle write-1-to-clear
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            poll_irq <= 1'b0;
            irq      <= 1'b0;
        end else begin
            poll_irq <= frame_done;
            irq      <= frame_done | (irq & ~(ctrl_wr & apb.PWDATA[31]));
        end
    end
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_gc_poll_tx.sv
// tb_gc_poll_tx: self-checking bench for gc_poll_tx using scaled-down timing parameters.
// Ports: none; drives APB via gc_poll_tx_if, pulls the data line up, checks frames and registers.
module tb_gc_poll_tx;
    localparam int Q     = 4;
    localparam int POLL  = 200;
    localparam int WIN   = 20;
    localparam int BIT_T = 4 * Q;
    localparam int WIN_T = WIN * Q;
    localparam int PER_T = POLL * Q;
`ifdef GC_POLL_IRQ_EN
    localparam bit IRQB = 1'b1;
`else
    localparam bit IRQB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ready;
    wire  data;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
`ifdef GC_POLL_IRQ_EN
    logic poll_irq;
`endif

    gc_poll_tx_if bus ();
    pullup (data);

    gc_poll_tx #(.CLK_PER_US(Q), .POLL_PERIOD_US(POLL), .RESP_WINDOW_US(WIN)) dut (
        .PCLK(clk),
        .PRESET(rst),
        .apb(bus),
        .data(data),
        .ready(ready)
`ifdef GC_POLL_IRQ_EN
        ,
        .poll_irq(poll_irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        assert (PER_T > 97 * Q + WIN_T) else begin
            $display("FAIL period_assert: period %0d not above frame+window %0d", PER_T, 97 * Q + WIN_T);
            $fatal(1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // callers are positioned just after a negedge
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] wd);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = addr; bus.PWDATA = wd; bus.PENABLE = 1'b0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] rd);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = addr; bus.PENABLE = 1'b0;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        rd = bus.PRDATA;
        @(negedge clk);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wait_low(output bit to);
        int n = 0;
        while (data !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        to = n >= 2000;
    endtask

    int lo_len[25];
    int hi_len[25];
    int rdy_len;
    int start_cyc;
    int overlap;
    bit timeout;

    // records low/high run lengths of 24 bits + stop, then the ready run
    task automatic capture();
        overlap = 0;
        rdy_len = 0;
        wait_low(timeout);
        if (timeout) return;
        start_cyc = cyc;
        for (int i = 0; i < 25; i++) begin
            lo_len[i] = 0;
            hi_len[i] = 0;
            while (data === 1'b0 && lo_len[i] < 1000) begin
                if (ready !== 1'b0) overlap++;
                lo_len[i]++;
                @(negedge clk);
            end
            if (i < 24)
                while (data === 1'b1 && hi_len[i] < 1000) begin hi_len[i]++; @(negedge clk); end
        end
        while (ready === 1'b1 && rdy_len < 1000) begin rdy_len++; @(negedge clk); end
    endtask

    task automatic check_frame(input string tag, input logic [23:0] exp_cmd);
        logic [23:0] got = '0;
        int bad = 0;
        chk({tag, "_timeout"}, 32'(timeout), 0);
        if (!timeout) begin
            for (int i = 0; i < 24; i++) begin
                got[23 - i] = lo_len[i] == Q;
                if (lo_len[i] != Q && lo_len[i] != 3 * Q) bad++;
                if (lo_len[i] + hi_len[i] != BIT_T) bad++;
            end
            chk({tag, "_cmd"}, 32'(got), 32'(exp_cmd));
            chk({tag, "_bit_timing_errors"}, 32'(bad), 0);
            chk({tag, "_stop_low"}, 32'(lo_len[24]), Q);
            chk({tag, "_ready_len"}, 32'(rdy_len), WIN_T);
            chk({tag, "_ready_overlap"}, 32'(overlap), 0);
        end
    endtask

    function automatic logic [31:0] st(input int fc, input bit busy);
        return {fc[15:0], 13'b0, IRQB && fc != 0, 1'b0, busy};
    endfunction

    typedef struct {
        logic [31:0] wdata;
        logic [23:0] cmd;
        logic [31:0] ctrl_rd;
    } vec_t;

    initial begin
        vec_t        vecs[4];
        logic [31:0] r;
        bit          to;
        int          fc = 0;
        int          prev_start = 0;
        int          falls = 0;
        int          n;

        vecs[0] = '{32'h0000_0001, 24'h400300, 32'h1};
        vecs[1] = '{32'h0000_0003, 24'h400301, 32'h3};
        vecs[2] = '{32'hFFFF_FFF1, 24'h400300, 32'h1};
        vecs[3] = '{32'h0000_0003, 24'h400301, 32'h3};

        rst = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_data", 32'(data), 1);
        chk("reset_ready", 32'(ready), 0);
        apb_read(0, r); chk("reset_ctrl", r, 0);
        apb_read(4, r); chk("reset_status", r, 0);

        for (int i = 0; i < 4; i++) begin
            apb_write(0, vecs[i].wdata);
            capture();
            check_frame($sformatf("vec%0d", i), vecs[i].cmd);
            if (i > 0) chk($sformatf("vec%0d_spacing", i), 32'(start_cyc - prev_start), PER_T);
            prev_start = start_cyc;
            fc++;
            apb_read(0, r); chk($sformatf("vec%0d_ctrl", i), r, vecs[i].ctrl_rd);
            apb_read(4, r); chk($sformatf("vec%0d_status", i), r, st(fc, 0));
        end

        fork
            capture();
            begin
                wait_low(to);
                repeat (40) @(negedge clk);
                apb_write(0, 32'h1);
                apb_read(4, r);
                chk("busy_status", r, st(fc, 1));
            end
        join
        check_frame("rumble_old", 24'h400301);
        chk("rumble_spacing", 32'(start_cyc - prev_start), PER_T);
        prev_start = start_cyc;
        fc++;
        capture();
        check_frame("rumble_new", 24'h400300);
        chk("rumble_new_spacing", 32'(start_cyc - prev_start), PER_T);
        fc++;

        fork
            capture();
            begin
                wait_low(to);
                repeat (2) @(negedge clk);
                apb_write(0, 32'h0);
            end
        join
        check_frame("en_clear", 24'h400300);
        fc++;
        apb_read(4, r); chk("en_clear_status", r, st(fc, 0));
        repeat (2 * PER_T) begin
            @(negedge clk);
            if (data === 1'b0) falls++;
        end
        chk("en_clear_quiet", 32'(falls), 0);
        apb_read(4, r); chk("en_clear_status_idle", r, st(fc, 0));

        apb_write(0, 32'h1);
        wait_low(to);
        chk("rst_mid_start_timeout", 32'(to), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_data", 32'(data), 1);
        chk("rst_mid_ready", 32'(ready), 0);
        rst = 1'b0;
        apb_read(0, r); chk("rst_mid_ctrl", r, 0);
        apb_read(4, r); chk("rst_mid_status", r, 0);
        fc = 0;

`ifdef GC_POLL_IRQ_EN
        apb_write(0, 32'h1);
        capture();
        check_frame("irq", 24'h400300);
        chk("irq_pulse_high", 32'(poll_irq), 1);
        @(negedge clk);
        chk("irq_pulse_low", 32'(poll_irq), 0);
        apb_read(4, r); chk("irq_sticky_set", 32'(r[2]), 1);
        apb_write(0, 32'h8000_0001);
        apb_read(4, r); chk("irq_sticky_clear", 32'(r[2]), 0);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk("irq_ready_timeout", 32'(n >= 2000), 0);
        repeat (WIN_T - 2) @(negedge clk);
        apb_write(0, 32'h8000_0001);
        chk("irq_coincident_ready_low", 32'(ready), 0);
        apb_read(4, r); chk("irq_set_wins", 32'(r[2]), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
